// File: rtl/line_buffer_ctrl.sv
// Frame sequencer for the 5-row line buffer: accepts one pixel frame, drives the
// buffer's clear/shift controls and flags completed conv or pool windows.
module line_buffer_ctrl #(
  parameter int DATA_WIDTH        = 8,
  parameter int MAX_WIDTH         = 32,
  parameter int FEATURE_MAP1_SIZE = 32,
  parameter int FEATURE_MAP2_SIZE = 28,
  parameter int FEATURE_MAP3_SIZE = 14,
  parameter int FEATURE_MAP4_SIZE = 10,
  parameter int FEATURE_MAP5_SIZE = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [2:0]                   mode,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         lb_clear,
  output logic                         lb_shift_en,
  output logic [DATA_WIDTH-1:0]        lb_data,
  output logic [2:0]                   lb_mode,
  output logic                         win_valid,
  output logic [$clog2(MAX_WIDTH)-1:0] win_row,
  output logic [$clog2(MAX_WIDTH)-1:0] win_col,
  output logic                         win_last
);
  localparam int CW = $clog2(MAX_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Frame side minus one, so a 32-pixel side still fits the coordinate width.
  function automatic logic [CW-1:0] side_m1(input logic [2:0] m);
    case (m)
      3'd0:    side_m1 = CW'(FEATURE_MAP1_SIZE - 1);
      3'd1:    side_m1 = CW'(FEATURE_MAP2_SIZE - 1);
      3'd2:    side_m1 = CW'(FEATURE_MAP3_SIZE - 1);
      3'd3:    side_m1 = CW'(FEATURE_MAP4_SIZE - 1);
      3'd4:    side_m1 = CW'(FEATURE_MAP5_SIZE - 1);
      3'd5:    side_m1 = CW'(FEATURE_MAP2_SIZE - 1);
      3'd6:    side_m1 = CW'(FEATURE_MAP4_SIZE - 1);
      3'd7:    side_m1 = CW'(FEATURE_MAP3_SIZE - 1);
      default: side_m1 = CW'(FEATURE_MAP1_SIZE - 1);
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [2:0]      mode_q, mode_d;
  logic [CW-1:0]   row_q, row_d, col_q, col_d;
  logic            win_valid_q, win_valid_d;
  logic [CW-1:0]   win_row_q, win_row_d, win_col_q, win_col_d;
  logic            win_last_q, win_last_d;

  logic [CW-1:0]   wm1_s;
  logic            is_pool_s, accept_s, last_pix_s, qual_s;

  // Abort wins over a simultaneous handshake, so that pixel is never taken.
  assign wm1_s      = side_m1(mode_q);
  assign is_pool_s  = (mode_q >= 3'd5);
  assign accept_s   = (state_q == S_RUN) && s_valid && !abort;
  assign last_pix_s = (row_q == wm1_s) && (col_q == wm1_s);
  assign qual_s     = is_pool_s ? (row_q[0] && col_q[0])
                                : ((row_q >= CW'(4)) && (col_q >= CW'(4)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
        else       state_d = S_IDLE;
      end
      S_CLEAR: begin
        if (abort) state_d = S_IDLE;
        else       state_d = S_RUN;
      end
      S_RUN: begin
        if (abort)                      state_d = S_IDLE;
        else if (accept_s && last_pix_s) state_d = S_DONE;
        else                            state_d = S_RUN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    s_ready     = (state_q == S_RUN);
    lb_clear    = (state_q == S_CLEAR);
    done        = (state_q == S_DONE);
    lb_shift_en = accept_s;
    if (accept_s) lb_data = s_data;
    else          lb_data = {DATA_WIDTH{1'b0}};
    lb_mode     = mode_q;
    win_valid   = win_valid_q;
    win_row     = win_row_q;
    win_col     = win_col_q;
    win_last    = win_last_q;
  end

  // Raster counters plus the window flag for the pixel accepted this cycle.
  always_comb begin
    mode_d = mode_q;
    row_d  = row_q;
    col_d  = col_q;
    if ((state_q == S_IDLE) && start) begin
      mode_d = mode;
      row_d  = {CW{1'b0}};
      col_d  = {CW{1'b0}};
    end else if (accept_s) begin
      if (col_q == wm1_s) begin
        col_d = {CW{1'b0}};
        row_d = row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      row_d = row_q;
    end
    win_valid_d = accept_s && qual_s;
    win_last_d  = accept_s && qual_s && last_pix_s;
    if (win_valid_d) begin
      win_row_d = is_pool_s ? (row_q >> 1) : (row_q - CW'(4));
      win_col_d = is_pool_s ? (col_q >> 1) : (col_q - CW'(4));
    end else begin
      win_row_d = {CW{1'b0}};
      win_col_d = {CW{1'b0}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= 3'd0;
      row_q       <= {CW{1'b0}};
      col_q       <= {CW{1'b0}};
      win_valid_q <= 1'b0;
      win_row_q   <= {CW{1'b0}};
      win_col_q   <= {CW{1'b0}};
      win_last_q  <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      row_q       <= row_d;
      col_q       <= col_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_last_q  <= win_last_d;
    end
  end
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Scoreboard bench for line_buffer_ctrl: the driver queues expected windows,
// a negedge monitor pops and compares them whenever win_valid is high.
module tb_line_buffer_ctrl;
  logic       clk, rst, start, abort, s_valid;
  logic [2:0] mode;
  logic [7:0] s_data;
  logic       busy, done, s_ready, lb_clear, lb_shift_en, win_valid, win_last;
  logic [7:0] lb_data;
  logic [2:0] lb_mode;
  logic [4:0] win_row, win_col;

  line_buffer_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .busy(busy), .done(done), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .lb_clear(lb_clear), .lb_shift_en(lb_shift_en),
    .lb_data(lb_data), .lb_mode(lb_mode), .win_valid(win_valid),
    .win_row(win_row), .win_col(win_col), .win_last(win_last)
  );

  typedef struct { int row; int col; int last; } win_t;
  win_t exp_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, win_cnt = 0, first_win_cyc = -1;
  int   acc_cyc[1024];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin : monitor
    win_t e;
    forever begin
      @(negedge clk);
      if (win_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("win_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("win_row", win_row, e.row);
          chk("win_col", win_col, e.col);
          chk("win_last", win_last, e.last);
        end
        if (win_cnt == 0) first_win_cyc = cyc;
        win_cnt++;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);         chk({tag, "_done"}, done, 0);
    chk({tag, "_s_ready"}, s_ready, 0);   chk({tag, "_lb_clear"}, lb_clear, 0);
    chk({tag, "_shift"}, lb_shift_en, 0); chk({tag, "_lb_data"}, lb_data, 0);
    chk({tag, "_lb_mode"}, lb_mode, 0);   chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_win_row"}, win_row, 0);   chk({tag, "_win_col"}, win_col, 0);
    chk({tag, "_win_last"}, win_last, 0);
  endtask

  // One frame: w is the side, n_exp/first_pix are hand-derived per test.
  task automatic run_frame(input int m, input int w, input bit is_pool, input int n_exp,
                           input int first_pix, input bit rnd, input int abort_at,
                           input int rst_at, input bit poke_start);
    int   idx = 0, guard = 0, r, c;
    bit   v, ab, rs, term = 0, acc;
    win_t e;
    win_cnt = 0;
    first_win_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; mode = 3'(m);
    @(posedge clk); #1;
    start = 1'b0; mode = ~3'(m);
    @(negedge clk);
    chk("clear_lb_clear", lb_clear, 1);
    chk("clear_busy", busy, 1);
    chk("clear_s_ready", s_ready, 0);
    @(posedge clk); #1;
    while (idx < w * w) begin
      v  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ab = (idx == abort_at) && v;
      rs = (idx == rst_at) && v;
      acc = v && !ab && !rs;
      s_valid = v; s_data = 8'(idx); abort = ab; rst = rs;
      start = poke_start && (idx == 5);
      if (acc) begin
        r = idx / w; c = idx % w;
        if (is_pool ? ((r % 2 == 1) && (c % 2 == 1)) : (r >= 4 && c >= 4)) begin
          e.row  = is_pool ? r / 2 : r - 4;
          e.col  = is_pool ? c / 2 : c - 4;
          e.last = (r == w - 1) && (c == w - 1);
          exp_q.push_back(e);
        end
      end
      @(negedge clk);
      chk("run_s_ready", s_ready, 1);
      chk("run_lb_clear", lb_clear, 0);
      chk("run_lb_mode", lb_mode, m);
      chk("run_shift_en", lb_shift_en, v && !ab);
      if (acc) begin
        chk("run_lb_data", lb_data, idx % 256);
        acc_cyc[idx] = cyc;
      end
      @(posedge clk); #1;
      if (ab || rs) begin
        term = 1'b1;
        break;
      end
      if (acc) idx++;
      guard++;
      if (guard > 5000) begin
        chk("frame_timeout", 1, 0);
        break;
      end
    end
    s_valid = 1'b0; abort = 1'b0; rst = 1'b0; start = 1'b0;
    if (term) begin
      @(negedge clk);
      if (rs) chk_reset_outputs("rst_mid");
      else begin
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_win_valid", win_valid, 0);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("term_done_after", done, 0);
    end else begin
      @(negedge clk);
      chk("end_done", done, 1);
      chk("end_win_valid", win_valid, 1);
      chk("end_win_last", win_last, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("end_done_pulse", done, 0);
      chk("end_busy", busy, 0);
      chk("win_count", win_cnt, n_exp);
      chk("first_win_latency", first_win_cyc, acc_cyc[first_pix] + 1);
    end
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; mode = 3'd0; s_data = 8'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    // mode, side, pool, windows, first qualifying pixel, rnd, abort_at, rst_at, poke
    run_frame(0, 32, 1'b0, 784, 132, 1'b0, -1, -1, 1'b0);
    run_frame(5, 28, 1'b1, 196, 29,  1'b0, -1, -1, 1'b0);
    run_frame(4, 5,  1'b0, 1,   24,  1'b0, -1, -1, 1'b1);
    run_frame(2, 14, 1'b0, 100, 60,  1'b1, -1, -1, 1'b0);
    run_frame(1, 28, 1'b0, 0,   0,   1'b0, 300, -1, 1'b0);
    run_frame(3, 10, 1'b0, 36,  44,  1'b0, -1, -1, 1'b0);
    run_frame(6, 10, 1'b1, 0,   0,   1'b0, -1, 40, 1'b0);
    run_frame(6, 10, 1'b1, 25,  11,  1'b0, -1, -1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
